adc_display_select: RTL and testbench
=====================================

Name: adc_display_select

Overview:
- Registered, parametrised source selector feeding the 7-segment display driver.
- Latches the most recent sample from each of NUM_CH ADC-derived channels (raw, averaged, scaled, ...).
- Selects one channel by manual step pulse or by timed auto-scan, and outputs its value with that channel's decimal-point pattern.
- Supports display hold and pulses an update strobe whenever the displayed value changes.

Parameters:
- NUM_CH, 4, number of input channels (2..16, need not be a power of two)
- DATA_W, 16, width of each channel value and of mux_out
- DP_W, 4, decimal-point pattern width (one bit per display digit)
- SCAN_TICKS, 100_000_000, clk cycles per auto-scan step (1 s at 100 MHz); minimum 2
- SEL_W, $clog2(NUM_CH) (minimum 1), derived selection width; not overridden by instantiators

Ports:
- clk  in  1  system clock; all state on the rising edge
- reset_n  in  1  asynchronous active-low reset
- in_data  in  NUM_CH*DATA_W  packed channel values; channel c occupies bits [c*DATA_W +: DATA_W]
- in_valid  in  NUM_CH  per-channel capture strobe, one cycle wide
- dp_cfg  in  NUM_CH*DP_W  per-channel decimal-point pattern; quasi-static
- mode_next  in  1  single-cycle pulse (already debounced) that advances the selection
- auto_scan_en  in  1  1 = timed auto-scan, 0 = manual only
- hold  in  1  1 = freeze display output and selection
- mux_out  out  DATA_W  displayed value
- decimal_point  out  DP_W  decimal-point pattern of the displayed channel
- sel_out  out  SEL_W  currently selected channel index
- out_valid  out  1  one-cycle pulse when mux_out/decimal_point were reloaded with a changed source

Behaviour:
- Reset:
  - Asynchronous on reset_n low: all channel latches, sel, scan counter, mux_out, decimal_point and out_valid go to 0, so sel_out = 0.
  - Release is synchronous to clk; first active edge is the first edge with reset_n high.
  - Reset mid-operation discards all latched samples and in-progress scan counts.
- Channel latches:
  - On an edge with in_valid[c] = 1, latch[c] <= in_data slice c.
  - Captures continue while hold = 1, so the latest value shows on release.
  - Several channels may capture in the same cycle.
- Selection (sel):
  - Advance = sel <= (sel == NUM_CH-1) ? 0 : sel+1. Never reaches an index >= NUM_CH.
  - Manual: a mode_next pulse advances sel by one, every cycle it is high, with no auto-repeat.
  - Auto (auto_scan_en = 1): the scan counter counts 0..SCAN_TICKS-1; the wrap edge produces a tick that advances sel.
  - mode_next in auto mode advances sel and clears the counter to 0.
  - Tick and mode_next on the same edge: exactly one advance.
  - auto_scan_en = 0: counter held at 0, so re-enabling always gives a full SCAN_TICKS interval.
  - hold = 1: sel and counter frozen; mode_next ignored (dropped, not queued).
- Output register, loaded when hold = 0:
  - mux_out <= latch[sel_next], decimal_point <= dp_cfg[sel_next], where sel_next is the value sel takes on this edge.
- Latency:
  - Selection: the advance edge updates sel_out and mux_out/decimal_point on that same edge; the new channel's value and decimal point are visible after 1 cycle.
  - Data: in_valid on edge N updates latch[c] at N; if c is selected, mux_out shows it after edge N+1.
- out_valid:
  - Registered; high for exactly one cycle following any edge where, with hold = 0, sel changed or the currently selected latch was written.
  - Also asserted once on the first edge after hold falls.
  - Never asserted while hold = 1 or in reset.
- dp_cfg changes propagate within 1 cycle (hold = 0) without an out_valid pulse.

Decomposition:
- Package adc_disp_pkg holds:
  - Default parameter constants: NUM_CH, DATA_W, DP_W, 100 MHz SCAN_TICKS.
  - Named DP patterns: DP_NONE = 4'b0000, DP_SCALED_V = 4'b0010.
  - Channel index constants: CH_AVG_EXT = 0, CH_SCALED = 1, CH_RAW = 2, CH_AUX = 3.
- One sub-module, display_scan_timer:
  - Inputs: clk, reset_n, enable, clear.
  - Parameter: SCAN_TICKS.
  - Output: a one-cycle tick at the counter wrap.
- Latches, selection and output register remain in adc_display_select.

Test Plan (NUM_CH=4, DATA_W=16, DP_W=4, SCAN_TICKS=8):
- Reset/capture:
  - Stimulus: assert reset_n=0 mid-run, release, then in_valid=4'b0001 with ch0=16'h0ABC.
  - Required: all outputs 0 during reset; after the capture, mux_out=16'h0ABC one cycle later, with a single out_valid pulse.
- Manual wrap:
  - Stimulus: load ch0..3 = 16'h1111/2222/3333/4444 with dp_cfg ch1 = 4'b0010; pulse mode_next 5 times.
  - Required: sel_out sequence 1,2,3,0,1. Each step shows the matching value, decimal_point = 4'b0010 only at sel 1, one out_valid per step.
- Auto-scan:
  - Stimulus: auto_scan_en=1 for 40 cycles.
  - Required: sel advances every 8 cycles (0→1→2→3→0→1).
  - Stimulus: mode_next pulsed on the same edge as a tick.
  - Required: a single advance, and the next tick comes 8 cycles later.
- Hold:
  - Stimulus: hold=1 at sel 2 showing 16'h3333; write ch2 = 16'h5555; pulse mode_next.
  - Required: mux_out stays 16'h3333 and sel_out stays 2, with no out_valid.
  - Stimulus: release hold.
  - Required: mux_out = 16'h5555 after 1 cycle, with one out_valid.
- Non-power-of-two:
  - Stimulus: NUM_CH=3, 4 mode_next pulses.
  - Required: sel_out 1,2,0,1; never 3.
- Unselected update:
  - Stimulus: write ch3 while sel = 0.
  - Required: mux_out unchanged, no out_valid; selecting ch3 later shows the new value.

Source files
------------

// File: rtl/adc_disp_pkg.sv
// Shared defaults, decimal-point patterns and channel indices for the
// ADC display source selector.
package adc_disp_pkg;

    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_DP_W       = 4;
    localparam int DEF_SCAN_TICKS = 100_000_000;

    localparam logic [3:0] DP_NONE     = 4'b0000;
    localparam logic [3:0] DP_SCALED_V = 4'b0010;

    typedef enum logic [1:0] {
        CH_AVG_EXT = 2'd0,
        CH_SCALED  = 2'd1,
        CH_RAW     = 2'd2,
        CH_AUX     = 2'd3
    } ch_idx_e;

endpackage

// File: rtl/display_scan_timer.sv
// Free-running auto-scan interval counter; emits a one-cycle tick on the
// edge where it wraps from SCAN_TICKS-1 back to 0.
module display_scan_timer #(
    parameter int SCAN_TICKS = 100_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (SCAN_TICKS > 2) ? $clog2(SCAN_TICKS) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick reflects the wrap edge even when clear lands on the same edge,
    // so a coincident manual step still yields exactly one advance upstream.
    assign tick = enable && (cnt_q == CNT_W'(SCAN_TICKS - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_display_select.sv
// Latches the latest sample of each ADC-derived channel and presents the
// selected one (manual step or timed scan) to the 7-segment driver.
module adc_display_select
    import adc_disp_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DP_W       = DEF_DP_W,
    parameter int SCAN_TICKS = DEF_SCAN_TICKS,
    localparam int SEL_W     = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DP_W-1:0]   dp_cfg,
    input  logic                     mode_next,
    input  logic                     auto_scan_en,
    input  logic                     hold,
    output logic [DATA_W-1:0]        mux_out,
    output logic [DP_W-1:0]          decimal_point,
    output logic [SEL_W-1:0]         sel_out,
    output logic                     out_valid
);

    logic [DATA_W-1:0] latch_w [NUM_CH];

    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] mux_q, mux_d;
    logic [DP_W-1:0]   dp_q, dp_d;
    logic              ov_q, ov_d;
    logic              wr_pend_q, wr_pend_d;
    logic              hold_q;

    logic              scan_tick;
    logic              scan_en;
    logic              scan_clr;
    logic              advance;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [DATA_W-1:0] lat_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                lat_q <= '0;
            end else if (in_valid[gi]) begin
                lat_q <= in_data[gi*DATA_W +: DATA_W];
            end
        end

        assign latch_w[gi] = lat_q;
    end

    // With auto-scan off the counter sits at 0, so re-enabling starts a
    // full interval; under hold it is frozen rather than cleared.
    assign scan_en  = auto_scan_en && !hold;
    assign scan_clr = !auto_scan_en || (mode_next && !hold);

    display_scan_timer #(
        .SCAN_TICKS(SCAN_TICKS)
    ) u_scan_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (scan_en),
        .clear  (scan_clr),
        .tick   (scan_tick)
    );

    assign advance = !hold && (mode_next || (auto_scan_en && scan_tick));

    always_comb begin
        sel_d     = sel_q;
        mux_d     = mux_q;
        dp_d      = dp_q;
        wr_pend_d = 1'b0;
        ov_d      = 1'b0;

        if (advance) begin
            sel_d = (sel_q == SEL_W'(NUM_CH - 1)) ? '0 : sel_q + 1'b1;
        end

        if (!hold) begin
            mux_d     = latch_w[sel_d];
            dp_d      = dp_cfg[int'(sel_d)*DP_W +: DP_W];
            // A write to the channel being shown reaches mux_out one edge
            // later; remember it so the strobe lines up with the new value.
            wr_pend_d = in_valid[sel_d];
            ov_d      = (sel_d != sel_q) || wr_pend_q || hold_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q     <= '0;
            mux_q     <= '0;
            dp_q      <= '0;
            ov_q      <= 1'b0;
            wr_pend_q <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            mux_q     <= mux_d;
            dp_q      <= dp_d;
            ov_q      <= ov_d;
            wr_pend_q <= wr_pend_d;
            hold_q    <= hold;
        end
    end

    assign mux_out       = mux_q;
    assign decimal_point = dp_q;
    assign sel_out       = sel_q;
    assign out_valid     = ov_q;

endmodule

// File: tb/tb_adc_display_select.sv
// Self-checking bench for adc_display_select: a 4-channel instance with an
// 8-cycle scan interval plus a 3-channel instance for non-power-of-two wrap.
module tb_adc_display_select;
    import adc_disp_pkg::*;

    localparam int NC  = 4;
    localparam int DW  = 16;
    localparam int DPW = 4;
    localparam int ST  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [NC*DW-1:0]  in_data;
    logic [NC-1:0]     in_valid;
    logic [NC*DPW-1:0] dp_cfg;
    logic              mode_next, auto_scan_en, hold;
    logic [DW-1:0]     mux_out;
    logic [DPW-1:0]    decimal_point;
    logic [1:0]        sel_out;
    logic              out_valid;

    logic [3*DW-1:0]   in_data3;
    logic [2:0]        in_valid3;
    logic [3*DPW-1:0]  dp_cfg3;
    logic              mode_next3;
    logic [DW-1:0]     mux3;
    logic [DPW-1:0]    dp3;
    logic [1:0]        sel3;
    logic              ov3;

    adc_display_select #(.NUM_CH(NC), .DATA_W(DW), .DP_W(DPW), .SCAN_TICKS(ST)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .dp_cfg(dp_cfg), .mode_next(mode_next), .auto_scan_en(auto_scan_en),
        .hold(hold), .mux_out(mux_out), .decimal_point(decimal_point),
        .sel_out(sel_out), .out_valid(out_valid)
    );

    adc_display_select #(.NUM_CH(3), .DATA_W(DW), .DP_W(DPW), .SCAN_TICKS(ST)) dut3 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data3), .in_valid(in_valid3),
        .dp_cfg(dp_cfg3), .mode_next(mode_next3), .auto_scan_en(1'b0),
        .hold(1'b0), .mux_out(mux3), .decimal_point(dp3),
        .sel_out(sel3), .out_valid(ov3)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       nm;
        logic [1:0]  sel;
        logic [15:0] mux;
        logic [3:0]  dp;
        logic        ov;
    } exp_t;

    exp_t sbq[$];

    // Queue what the display must show after the coming edge, then compare.
    task automatic expect_next(input string nm, input logic [1:0] s, input logic [15:0] m,
                               input logic [3:0] d, input logic o);
        exp_t e;
        e.nm = nm; e.sel = s; e.mux = m; e.dp = d; e.ov = o;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({e.nm, ".sel"}, 32'(sel_out), 32'(e.sel));
        chk({e.nm, ".mux"}, 32'(mux_out), 32'(e.mux));
        chk({e.nm, ".dp"},  32'(decimal_point), 32'(e.dp));
        chk({e.nm, ".ov"},  32'(out_valid), 32'(e.ov));
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] mux;
        logic [3:0]  dp;
    } man_t;

    man_t        man_tab[5];
    logic [15:0] vals[4];
    logic [3:0]  dps[4];
    logic [15:0] vals3[3];
    logic [1:0]  s_exp;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        in_data = '0; in_valid = '0; dp_cfg = '0;
        mode_next = 1'b0; auto_scan_en = 1'b0; hold = 1'b0; reset_n = 1'b0;
        in_data3 = '0; in_valid3 = '0; dp_cfg3 = '0; mode_next3 = 1'b0;

        vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        dps  = '{DP_NONE, DP_SCALED_V, DP_NONE, DP_NONE};
        man_tab[0] = '{2'd1, 16'h2222, DP_SCALED_V};
        man_tab[1] = '{2'd2, 16'h3333, DP_NONE};
        man_tab[2] = '{2'd3, 16'h4444, DP_NONE};
        man_tab[3] = '{2'd0, 16'h1111, DP_NONE};
        man_tab[4] = '{2'd1, 16'h2222, DP_SCALED_V};
        vals3 = '{16'hAAAA, 16'hBBBB, 16'hCCCC};

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Some state before a mid-run reset
        in_data[31:16] = 16'h1234; in_valid = 4'b0010; mode_next = 1'b1;
        @(posedge clk); #1;
        in_valid = '0; mode_next = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst.sel", 32'(sel_out), 32'd1);
        chk("pre_rst.mux", 32'(mux_out), 32'h1234);

        #2 reset_n = 1'b0;
        #1;
        chk("rst.sel", 32'(sel_out), 32'd0);
        chk("rst.mux", 32'(mux_out), 32'd0);
        chk("rst.dp",  32'(decimal_point), 32'd0);
        chk("rst.ov",  32'(out_valid), 32'd0);
        chk("rst3.sel", 32'(sel3), 32'd0);
        @(posedge clk); #1;
        chk("rst_edge.mux", 32'(mux_out), 32'd0);
        reset_n = 1'b1;

        // Capture on ch0: value after one extra edge, single strobe
        in_data[15:0] = 16'h0ABC; in_valid = 4'b0001;
        expect_next("cap0", 2'd0, 16'h0000, DP_NONE, 1'b0);
        in_valid = '0;
        expect_next("cap1", 2'd0, 16'h0ABC, DP_NONE, 1'b1);
        expect_next("cap2", 2'd0, 16'h0ABC, DP_NONE, 1'b0);

        // Load all channels at once
        in_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        in_valid = 4'hF;
        dp_cfg = 16'h0020;
        expect_next("load0", 2'd0, 16'h0ABC, DP_NONE, 1'b0);
        in_valid = '0;
        expect_next("load1", 2'd0, 16'h1111, DP_NONE, 1'b1);
        expect_next("load2", 2'd0, 16'h1111, DP_NONE, 1'b0);

        // Manual stepping with wrap
        for (int i = 0; i < 5; i++) begin
            mode_next = 1'b1;
            expect_next($sformatf("man_step%0d", i), man_tab[i].sel, man_tab[i].mux, man_tab[i].dp, 1'b1);
            mode_next = 1'b0;
            expect_next($sformatf("man_idle%0d", i), man_tab[i].sel, man_tab[i].mux, man_tab[i].dp, 1'b0);
        end

        // dp_cfg change on the shown channel: follows in one cycle, no strobe
        dp_cfg = 16'h0090;
        expect_next("dpcfg", 2'd1, 16'h2222, 4'b1001, 1'b0);
        dp_cfg = 16'h0020;
        expect_next("dpcfg_back", 2'd1, 16'h2222, DP_SCALED_V, 1'b0);

        // Auto-scan: advance every ST cycles from sel 1
        auto_scan_en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            s_exp = 2'((1 + k / ST) % 4);
            expect_next($sformatf("auto%0d", k), s_exp, vals[s_exp], dps[s_exp], (k % ST) == 0);
        end
        for (int k = 41; k < 48; k++) begin
            expect_next($sformatf("auto%0d", k), 2'd2, vals[2], dps[2], 1'b0);
        end
        mode_next = 1'b1;
        expect_next("auto_tick_mn", 2'd3, vals[3], dps[3], 1'b1);
        mode_next = 1'b0;
        for (int j = 1; j <= ST; j++) begin
            s_exp = (j == ST) ? 2'd0 : 2'd3;
            expect_next($sformatf("auto_after%0d", j), s_exp, vals[s_exp], dps[s_exp], j == ST);
        end
        auto_scan_en = 1'b0;

        // Step to ch2, then hold
        mode_next = 1'b1;
        expect_next("to1", 2'd1, vals[1], dps[1], 1'b1);
        expect_next("to2", 2'd2, vals[2], dps[2], 1'b1);
        mode_next = 1'b0;
        expect_next("at2", 2'd2, 16'h3333, DP_NONE, 1'b0);

        hold = 1'b1;
        in_data[47:32] = 16'h5555; in_valid = 4'b0100; mode_next = 1'b1;
        expect_next("hold0", 2'd2, 16'h3333, DP_NONE, 1'b0);
        in_valid = '0; mode_next = 1'b0;
        expect_next("hold1", 2'd2, 16'h3333, DP_NONE, 1'b0);
        mode_next = 1'b1;
        expect_next("hold2", 2'd2, 16'h3333, DP_NONE, 1'b0);
        mode_next = 1'b0;
        expect_next("hold3", 2'd2, 16'h3333, DP_NONE, 1'b0);
        vals[2] = 16'h5555;
        hold = 1'b0;
        expect_next("unhold0", 2'd2, 16'h5555, DP_NONE, 1'b1);
        expect_next("unhold1", 2'd2, 16'h5555, DP_NONE, 1'b0);

        // Write an unselected channel
        mode_next = 1'b1;
        expect_next("to3", 2'd3, vals[3], dps[3], 1'b1);
        expect_next("to0", 2'd0, vals[0], dps[0], 1'b1);
        mode_next = 1'b0;
        in_data[63:48] = 16'h9999; in_valid = 4'b1000;
        expect_next("unsel0", 2'd0, 16'h1111, DP_NONE, 1'b0);
        in_valid = '0;
        expect_next("unsel1", 2'd0, 16'h1111, DP_NONE, 1'b0);
        vals[3] = 16'h9999;
        mode_next = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            s_exp = 2'(i);
            expect_next($sformatf("resel%0d", i), s_exp, vals[s_exp], dps[s_exp], 1'b1);
        end
        mode_next = 1'b0;
        expect_next("resel_idle", 2'd3, 16'h9999, DP_NONE, 1'b0);

        // Three-channel instance: wrap at index 2
        in_data3 = {vals3[2], vals3[1], vals3[0]};
        in_valid3 = 3'b111;
        @(posedge clk); #1;
        in_valid3 = '0;
        @(posedge clk); #1;
        chk("n3_load.mux", 32'(mux3), 32'hAAAA);
        for (int i = 0; i < 4; i++) begin
            mode_next3 = 1'b1;
            @(posedge clk); #1;
            mode_next3 = 1'b0;
            s_exp = 2'((i + 1) % 3);
            chk($sformatf("n3_step%0d.sel", i), 32'(sel3), 32'(s_exp));
            chk($sformatf("n3_step%0d.mux", i), 32'(mux3), 32'(vals3[s_exp]));
            chk($sformatf("n3_step%0d.ov", i), 32'(ov3), 32'd1);
            @(posedge clk); #1;
            chk($sformatf("n3_idle%0d.sel", i), 32'(sel3), 32'(s_exp));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
